// File: rtl/control.sv
// Main opcode decoder for the single-cycle datapath.
// Combinational control strobes plus a sticky illegal-opcode flag.
module control (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] ctrl,
  output logic       branch,
  output logic       RegWrite,
  output logic       MemtoReg,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       alu_src,
  output logic [1:0] alu_op,
  output logic       illegal_op
);

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic known;

  always_comb begin
    branch   = 1'b0;
    RegWrite = 1'b0;
    MemtoReg = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    alu_src  = 1'b0;
    alu_op   = 2'b00;
    known    = 1'b1;
    case (ctrl)
      OP_RTYPE: begin
        RegWrite = 1'b1;
        alu_op   = 2'b10;
      end
      OP_LOAD: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        MemRead  = 1'b1;
        alu_src  = 1'b1;
      end
      OP_STORE: begin
        MemWrite = 1'b1;
        alu_src  = 1'b1;
      end
      OP_BRANCH: begin
        branch = 1'b1;
        alu_op = 2'b01;
      end
      default: known = 1'b0;
    endcase
    // reset masks the strobes without waiting for a clock edge
    if (rst) begin
      branch   = 1'b0;
      RegWrite = 1'b0;
      MemtoReg = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      alu_src  = 1'b0;
      alu_op   = 2'b00;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      illegal_op <= 1'b0;
    else if (!known)
      illegal_op <= 1'b1;
  end

endmodule

// File: tb/tb_control.sv
// Scoreboard bench for the opcode decoder.
// Stimulus queues expected rows; a monitor pops and compares them.
module tb_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] ctrl;
  logic       branch, RegWrite, MemtoReg, MemRead, MemWrite, alu_src;
  logic [1:0] alu_op;
  logic       illegal_op;

  control dut (
    .clk(clk), .rst(rst), .ctrl(ctrl),
    .branch(branch), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .MemRead(MemRead), .MemWrite(MemWrite), .alu_src(alu_src),
    .alu_op(alu_op), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] v;
    string      name;
  } exp_t;

  exp_t q[$];
  event chk;
  int total = 0;
  int bad = 0;

  // {br, RW, M2R, MR, MW, src, alu_op, illegal}
  localparam logic [7:0] R_ROW  = 8'b0_1_0_0_0_0_10;
  localparam logic [7:0] LD_ROW = 8'b0_1_1_1_0_1_00;
  localparam logic [7:0] ST_ROW = 8'b0_0_0_0_1_1_00;
  localparam logic [7:0] BR_ROW = 8'b1_0_0_0_0_0_01;
  localparam logic [7:0] NOP    = 8'b0_0_0_0_0_0_00;

  task automatic step(input bit edge_wait, input logic r,
                      input logic [6:0] c, input logic [7:0] row,
                      input logic ill, input string name);
    exp_t e;
    if (edge_wait) @(negedge clk);
    else #2;
    rst  = r;
    ctrl = c;
    e.v    = {row, ill};
    e.name = name;
    q.push_back(e);
    -> chk;
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    logic [8:0] act;
    forever begin
      @(chk);
      #1;
      act = {branch, RegWrite, MemtoReg, MemRead, MemWrite,
             alu_src, alu_op, illegal_op};
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL %s: no expected entry, got %b", "scoreboard", act);
      end else begin
        e = q.pop_front();
        if (act !== e.v) begin
          bad++;
          $display("FAIL %s: got %b want %b", e.name, act, e.v);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst  = 1'b1;
    ctrl = 7'b0110011;
    step(1, 1, 7'b0110011, NOP,    0, "reset");
    step(1, 0, 7'b0110011, R_ROW,  0, "rtype");
    step(1, 0, 7'b0000011, LD_ROW, 0, "load");
    step(1, 0, 7'b0100011, ST_ROW, 0, "store");
    step(1, 0, 7'b1100011, BR_ROW, 0, "branch");
    step(1, 0, 7'b0110010, NOP,    0, "partial_rtype");
    step(1, 0, 7'b0110011, R_ROW,  1, "sticky_set");
    step(1, 0, 7'b1111111, NOP,    1, "all_ones");
    step(1, 1, 7'b0000011, NOP,    0, "rst_forces_zero");
    step(0, 0, 7'b0000011, LD_ROW, 0, "rst_release");
    step(1, 0, 7'b0100011, ST_ROW, 0, "legal_no_flag");
    step(1, 0, 7'b0000000, NOP,    0, "zero_opcode");
    step(1, 0, 7'b1100011, BR_ROW, 1, "zero_flagged");
    step(0, 1, 7'b1100011, NOP,    0, "async_rst");
    step(1, 0, 7'b1100011, BR_ROW, 0, "after_rst");
    step(1, 0, 7'b1100111, NOP,    0, "partial_branch");
    step(1, 0, 7'b0110011, R_ROW,  1, "partial_flagged");
    #5;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d entries want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
